// File: rtl/osc_mon_pkg.sv
// osc_mon_pkg: shared types and constants for the oscillator frequency monitor.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
// Contents: measurement FSM state, result verdict struct, default window/counter
// sizes, and the gate counter width helper.
package osc_mon_pkg;

  // Measurement sequence: wait for a request, count over the gate window,
  // then publish the result for one cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    EVAL    = 2'd2
  } state_t;

  // Range verdict; exactly one bit is set once a measurement has completed.
  typedef struct packed {
    logic in_range;
    logic too_low;
    logic too_high;
  } verdict_t;

  localparam int DEF_GATE_CYCLES = 27000;
  localparam int DEF_CNT_W       = 16;

  // ceil(log2(cycles)), never less than 1. The gate counter only has to hold
  // 0..cycles-1, so this is always wide enough.
  function automatic int gate_cnt_width(input int cycles);
    int w;
    w = 31;
    for (int i = 30; i >= 1; i--) begin
      if ((32'd1 << i) >= cycles) begin
        w = i;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchronizer for an asynchronous level plus a registered rising-edge pulse.
// Latency: a 0->1 transition on d produces a one-cycle rise pulse 2-3 clk cycles later.
// Backpressure: none; free-running, one pulse per synchronized rising transition.
// Ports:
//   clk  - sampling clock
//   rst  - synchronous, active-high; clears every flop in the chain
//   d    - asynchronous input level
//   rise - one-cycle pulse per rising edge of d
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta;    // first stage, may go metastable; never used in logic
  logic sync;    // resolved level in the clk domain
  logic sync_q;  // previous resolved level, for edge detection

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_q <= sync;
      rise   <= sync & ~sync_q;
    end
  end

endmodule

// File: rtl/osc_freq_monitor.sv
// osc_freq_monitor: counts rising edges of an asynchronous monitored signal over a fixed clk gate window.
// Latency: done (with fresh results) pulses GATE_CYCLES+1 cycles after an accepted start.
// Backpressure: start is ignored while busy; no queuing, the running window is never restarted.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   mon_in            - monitored signal (asynchronous, toggle rate below clk/4)
//   start             - one-cycle request to begin a measurement
//   busy              - measurement in progress (MEASURE or EVAL)
//   done              - one-cycle pulse, results are valid in the same cycle
//   count             - saturating edge count of the last window
//   in_range/too_low/too_high - verdict of count against [MIN_COUNT, MAX_COUNT]
module osc_freq_monitor
  import osc_mon_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MIN_COUNT   = 0,
  parameter int MAX_COUNT   = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             in_range,
  output logic             too_low,
  output logic             too_high
);

  localparam int               GW        = gate_cnt_width(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic             rise;
  logic [GW-1:0]    gate_cnt;
  logic             gate_last;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_cnt_nxt;
  logic             cnt_clr;
  logic             cnt_run;
  logic             res_load;
  verdict_t         verdict_nxt;
  verdict_t         verdict_q;

  // Edge detection is free-running; the FSM decides which pulses count.
  sync_edge_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (mon_in),
    .rise (rise)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Gate counter runs 0..GATE_CYCLES-1 while in MEASURE, giving exactly
  // GATE_CYCLES counting cycles.
  assign gate_last = (gate_cnt == GATE_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = MEASURE;
      MEASURE: if (gate_last) state_nxt = EVAL;
      EVAL:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_run  = 1'b0;
    res_load = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
      end
      MEASURE: begin
        busy     = 1'b1;
        cnt_run  = 1'b1;
        // Results are captured on the last counting cycle so they are already
        // on the outputs during EVAL, alongside done.
        res_load = gate_last;
      end
      EVAL: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      gate_cnt <= '0;
    end else if (cnt_run) begin
      gate_cnt <= gate_cnt + GW'(1);
    end
  end

  // Saturating increment: a too-fast input pins the count at all-ones rather
  // than wrapping into a plausible-looking small value.
  assign edge_cnt_nxt = (rise && (edge_cnt != CNT_SAT)) ? edge_cnt + CNT_W'(1) : edge_cnt;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      edge_cnt <= '0;
    end else if (cnt_run) begin
      edge_cnt <= edge_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------- results
  // Compare in signed 32-bit so MIN_COUNT=0 / MAX_COUNT=all-ones do not turn
  // into constant unsigned comparisons.
  always_comb begin
    verdict_nxt = '0;
    if (int'(edge_cnt_nxt) < MIN_COUNT) begin
      verdict_nxt.too_low = 1'b1;
    end else if (int'(edge_cnt_nxt) > MAX_COUNT) begin
      verdict_nxt.too_high = 1'b1;
    end else begin
      verdict_nxt.in_range = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      verdict_q <= '0;
    end else if (res_load) begin
      count     <= edge_cnt_nxt;
      verdict_q <= verdict_nxt;
    end
  end

  assign in_range = verdict_q.in_range;
  assign too_low  = verdict_q.too_low;
  assign too_high = verdict_q.too_high;

endmodule

// File: tb/tb_osc_freq_monitor.sv
// tb_osc_freq_monitor: drives two monitor instances (16-bit and 4-bit counters)
// with the same stimulus and checks both against a reference built from the
// window/latency rules, plus directed scenarios with literal expectations.
module tb_osc_freq_monitor;

  localparam int G    = 100;
  localparam int MINC = 8;
  localparam int MAXC = 12;
  localparam int WA   = 16;
  localparam int WB   = 4;
  localparam int NCYC = 16000;

  logic clk;
  logic rst;
  logic start;
  logic mon_in;

  logic          busy_a, done_a, in_range_a, too_low_a, too_high_a;
  logic [WA-1:0] count_a;
  logic          busy_b, done_b, in_range_b, too_low_b, too_high_b;
  logic [WB-1:0] count_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  osc_freq_monitor #(.GATE_CYCLES(G), .CNT_W(WA), .MIN_COUNT(MINC), .MAX_COUNT(MAXC)) dut_a (
    .clk(clk), .rst(rst), .mon_in(mon_in), .start(start),
    .busy(busy_a), .done(done_a), .count(count_a),
    .in_range(in_range_a), .too_low(too_low_a), .too_high(too_high_a)
  );

  osc_freq_monitor #(.GATE_CYCLES(G), .CNT_W(WB), .MIN_COUNT(MINC), .MAX_COUNT(MAXC)) dut_b (
    .clk(clk), .rst(rst), .mon_in(mon_in), .start(start),
    .busy(busy_b), .done(done_b), .count(count_b),
    .in_range(in_range_b), .too_low(too_low_b), .too_high(too_high_b)
  );

  int n_cmp;
  int n_bad;
  int cyc;
  bit check_en;

  // Level seen by the synchronizer per cycle; a reset empties the
  // synchronizer, so the last samples before it read as low.
  bit eff [NCYC];
  bit p_start, p_rst;

  int mon_mode;  // 0 constant, 1 periodic, 2 random
  bit mon_const;
  int period;
  int hold;
  bit mon_r;

  // Reference state
  int       meas_s;
  bit       exp_busy, exp_done;
  int       exp_cnt_a, exp_cnt_b;
  bit [2:0] exp_v_a, exp_v_b;  // {in_range, too_low, too_high}

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Rising edges driven in cycles lo..hi.
  function automatic int rises(input int lo, input int hi);
    int n;
    n = 0;
    for (int r = lo; r <= hi; r++) begin
      if (r >= 1 && eff[r] && !eff[r-1]) n++;
    end
    return n;
  endfunction

  function automatic int sat(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  function automatic bit [2:0] verdict(input int n);
    if (n < MINC) return 3'b010;
    if (n > MAXC) return 3'b001;
    return 3'b100;
  endfunction

  // Expected outputs for cycle c+1 given the inputs of cycle c.
  // Measurement accepted in cycle s: busy s+1..s+G+1, done at s+G+1.
  // An input edge driven in cycle r is detected in cycle r+3, so the window
  // s+1..s+G covers edges driven in cycles s-2..s+G-3.
  task automatic model_step(input int c);
    int n;
    exp_done = 1'b0;
    if (p_rst) begin
      meas_s    = -1;
      exp_busy  = 1'b0;
      exp_cnt_a = 0;
      exp_cnt_b = 0;
      exp_v_a   = 3'b000;
      exp_v_b   = 3'b000;
    end else begin
      if (p_start && !exp_busy) meas_s = c;
      if (meas_s >= 0 && c + 1 == meas_s + G + 1) begin
        n         = rises(meas_s - 2, meas_s + G - 3);
        exp_cnt_a = sat(n, WA);
        exp_cnt_b = sat(n, WB);
        exp_v_a   = verdict(exp_cnt_a);
        exp_v_b   = verdict(exp_cnt_b);
        exp_done  = 1'b1;
      end
      exp_busy = (meas_s >= 0) && (c + 1 <= meas_s + G + 1);
      if (meas_s >= 0 && c + 1 > meas_s + G + 1) meas_s = -1;
    end
  endtask

  task automatic tick(input bit st, input bit rs);
    @(posedge clk);
    #1;
    if (cyc >= 0) begin
      model_step(cyc);
      check_en = 1'b1;
    end
    cyc++;
    case (mon_mode)
      0: mon_in = mon_const;
      1: mon_in = ((cyc % period) < (period / 2));
      default: begin
        if (hold == 0) begin
          mon_r = ~mon_r;
          hold  = $urandom_range(2, 6);
        end
        hold--;
        mon_in = mon_r;
      end
    endcase
    start   = st;
    rst     = rs;
    p_start = st;
    p_rst   = rs;
    eff[cyc] = rs ? 1'b0 : mon_in;
    if (rs && cyc >= 1) eff[cyc-1] = 1'b0;
  endtask

  task automatic do_measure(input string name);
    int s;
    int lat;
    tick(1'b1, 1'b0);
    s   = cyc;
    lat = -1;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      tick(1'b0, 1'b0);
      if (done_a === 1'b1) lat = cyc - s;
    end
    chk({name, "_latency"}, 32'(lat), G + 1);
  endtask

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy_a",     32'(busy_a),     int'(exp_busy));
      chk("done_a",     32'(done_a),     int'(exp_done));
      chk("count_a",    32'(count_a),    exp_cnt_a);
      chk("in_range_a", 32'(in_range_a), int'(exp_v_a[2]));
      chk("too_low_a",  32'(too_low_a),  int'(exp_v_a[1]));
      chk("too_high_a", 32'(too_high_a), int'(exp_v_a[0]));
      chk("busy_b",     32'(busy_b),     int'(exp_busy));
      chk("done_b",     32'(done_b),     int'(exp_done));
      chk("count_b",    32'(count_b),    exp_cnt_b);
      chk("in_range_b", 32'(in_range_b), int'(exp_v_b[2]));
      chk("too_low_b",  32'(too_low_b),  int'(exp_v_b[1]));
      chk("too_high_b", 32'(too_high_b), int'(exp_v_b[0]));
    end
  end

  initial begin
    int nd;
    int dc;
    logic b101;
    logic b102;

    n_cmp = 0; n_bad = 0; cyc = -1; check_en = 1'b0;
    rst = 1'b1; start = 1'b0; mon_in = 1'b0;
    mon_mode = 0; mon_const = 1'b0; period = 10; hold = 0; mon_r = 1'b0;
    p_start = 1'b0; p_rst = 1'b1;
    meas_s = -1; exp_busy = 1'b0; exp_done = 1'b0;
    exp_cnt_a = 0; exp_cnt_b = 0; exp_v_a = 3'b000; exp_v_b = 3'b000;

    // Reset state
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("reset_busy",    32'(busy_a),  0);
    chk("reset_count",   32'(count_a), 0);
    chk("reset_verdict", 32'({in_range_a, too_low_a, too_high_a}), 0);

    // Nominal: period 10 -> 10 edges, in range
    mon_mode = 1; period = 10;
    repeat (6) tick(1'b0, 1'b0);
    do_measure("nominal");
    chk("nominal_count_a",  32'(count_a),    10);
    chk("nominal_in_range", 32'(in_range_a), 1);
    chk("nominal_count_b",  32'(count_b),    10);
    tick(1'b0, 1'b0);
    chk("nominal_busy_after", 32'(busy_a), 0);

    // Slow: period 20 -> 5, too low
    period = 20;
    repeat (6) tick(1'b0, 1'b0);
    do_measure("slow");
    chk("slow_count",    32'(count_a),    5);
    chk("slow_too_low",  32'(too_low_a),  1);
    chk("slow_in_range", 32'(in_range_a), 0);

    // Fast: period 4 -> 25; 4-bit counter saturates at 15
    period = 4;
    repeat (6) tick(1'b0, 1'b0);
    do_measure("fast");
    chk("fast_count_a",    32'(count_a),    25);
    chk("fast_too_high_a", 32'(too_high_a), 1);
    chk("sat_count_b",     32'(count_b),    15);
    chk("sat_too_high_b",  32'(too_high_b), 1);

    // Start while busy: second start at +50 is ignored
    period = 10;
    repeat (6) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    nd = 0; dc = -1; b101 = 1'b0; b102 = 1'b1;
    for (int i = 1; i <= 115; i++) begin
      tick(i == 50, 1'b0);
      if (done_a === 1'b1) begin
        nd++;
        dc = i;
      end
      if (i == 101) b101 = busy_a;
      if (i == 102) b102 = busy_a;
    end
    chk("busy_start_done_count", 32'(nd),   1);
    chk("busy_start_done_cycle", 32'(dc),   G + 1);
    chk("busy_start_busy_101",   32'(b101), 1);
    chk("busy_start_busy_102",   32'(b102), 0);

    // Reset mid-measure at cycle 40
    tick(1'b1, 1'b0);
    repeat (39) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("midrst_busy",    32'(busy_a),     0);
    chk("midrst_done",    32'(done_a),     0);
    chk("midrst_count",   32'(count_a),    0);
    chk("midrst_verdict", 32'({in_range_a, too_low_a, too_high_a}), 0);
    nd = 0;
    for (int i = 0; i < 110; i++) begin
      tick(1'b0, 1'b0);
      if (done_a === 1'b1) nd++;
    end
    chk("midrst_no_done", 32'(nd), 0);
    do_measure("after_rst");
    chk("after_rst_count", 32'(count_a), 10);

    // Constant high, then constant low after reset
    mon_mode = 0; mon_const = 1'b1;
    repeat (6) tick(1'b0, 1'b0);
    do_measure("const1");
    chk("const1_count",   32'(count_a),   0);
    chk("const1_too_low", 32'(too_low_a), 1);
    repeat (2) tick(1'b0, 1'b1);
    mon_const = 1'b0;
    repeat (6) tick(1'b0, 1'b0);
    do_measure("const0");
    chk("const0_count",   32'(count_a),   0);
    chk("const0_too_low", 32'(too_low_a), 1);

    // Random input, random starts (many while busy), occasional resets
    mon_mode = 2;
    for (int i = 0; i < 6000; i++) begin
      tick($urandom_range(0, 24) == 0, $urandom_range(0, 499) == 0);
    end
    mon_mode = 0;
    repeat (3) tick(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
